// File: rtl/screen_switch_ctrl_pkg.sv
// Shared types for the screen switch controller.
//   game_mode_t  : applied screen mode (IDLE / SINGLE / MULTI)
//   ctrl_state_t : controller sequencing states
//   CNT_W        : width of the frame counter
//   decode_req() : one-hot screen request to mode code
package screen_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_MULTI  = 2'd2
  } game_mode_t;

  typedef enum logic [1:0] {
    ST_STABLE,
    ST_QUALIFY,
    ST_BLANK,
    ST_HOLD
  } ctrl_state_t;

  localparam int CNT_W = 4;

  // Anything other than exactly one request line high falls back to IDLE.
  function automatic game_mode_t decode_req(input logic idle,
                                            input logic single,
                                            input logic multi);
    game_mode_t m;
    case ({multi, single, idle})
      3'b001:  m = MODE_IDLE;
      3'b010:  m = MODE_SINGLE;
      3'b100:  m = MODE_MULTI;
      default: m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/screen_switch_ctrl_if.sv
// Signal bundle between the game-select front end / draw pipeline and the
// screen switch controller.
//   screen_idle/single/multi : one-hot screen request (from select_game_sm)
//   vblank_start             : one-cycle pulse at start of vertical blank
//   game_busy                : game logic still flushing
//   mode_out                 : applied screen mode
//   blank_out                : force black screen
//   game_reset / game_start  : one-cycle control pulses to the game logic
// Modports: master = request/timing side, slave = controller.
interface screen_switch_ctrl_if;
  import screen_switch_ctrl_pkg::*;

  logic       screen_idle;
  logic       screen_single;
  logic       screen_multi;
  logic       vblank_start;
  logic       game_busy;
  game_mode_t mode_out;
  logic       blank_out;
  logic       game_reset;
  logic       game_start;

  modport master (
    output screen_idle, screen_single, screen_multi, vblank_start, game_busy,
    input  mode_out, blank_out, game_reset, game_start
  );

  modport slave (
    input  screen_idle, screen_single, screen_multi, vblank_start, game_busy,
    output mode_out, blank_out, game_reset, game_start
  );

endinterface

// File: rtl/screen_switch_ctrl_frame_counter.sv
// Frame counter shared by request qualification and post-switch hold.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable (one vblank)
//   limit      : terminal count
//   hit        : high in the cycle whose counted frame reaches limit
module screen_switch_ctrl_frame_counter
  import screen_switch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    // Terminal count is flagged on the counting edge itself so the owner
    // can change state in the same cycle the final frame arrives.
    hit     = en && !clr && (cnt_inc == limit);
    cnt_d   = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/screen_switch_ctrl.sv
// Screen switch controller: debounces the one-hot screen request over whole
// video frames, then sequences blank -> game reset -> apply mode on a frame
// boundary -> hold blanked -> unblank and start the game.
//   clk65MHz : system clock
//   rst      : asynchronous active-low reset
//   sw       : screen_switch_ctrl_if.slave (requests, vblank, busy in;
//              mode/blank/pulses out, all registered)
module screen_switch_ctrl
  import screen_switch_ctrl_pkg::*;
#(
  parameter int STABLE_FRAMES = 4,
  parameter int HOLD_FRAMES   = 2
) (
  input  logic                 clk65MHz,
  input  logic                 rst,
  screen_switch_ctrl_if.slave  sw
);

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_FRAMES);

  ctrl_state_t      state_q, state_d;
  game_mode_t       mode_q, mode_d;
  game_mode_t       cand_q, cand_d;
  logic             blank_q, blank_d;
  logic             game_reset_q, game_reset_d;
  logic             game_start_q, game_start_d;

  game_mode_t       req;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_hit;

  screen_switch_ctrl_frame_counter u_frame_counter (
    .clk   (clk65MHz),
    .rst_n (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_limit),
    .hit   (cnt_hit)
  );

  always_comb begin
    req          = decode_req(sw.screen_idle, sw.screen_single, sw.screen_multi);
    state_d      = state_q;
    mode_d       = mode_q;
    cand_d       = cand_q;
    blank_d      = blank_q;
    game_reset_d = 1'b0;
    game_start_d = 1'b0;
    cnt_clr      = 1'b1;
    cnt_en       = 1'b0;
    cnt_limit    = STABLE_LIM;

    case (state_q)
      ST_STABLE: begin
        if (req != mode_q) begin
          cand_d  = req;
          state_d = ST_QUALIFY;
        end
      end

      ST_QUALIFY: begin
        if (req == mode_q) begin
          state_d = ST_STABLE;
        end else if (req != cand_q) begin
          // New candidate restarts qualification; a vblank in this cycle
          // belongs to the old candidate and is dropped.
          cand_d = req;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = sw.vblank_start;
          if (cnt_hit) begin
            state_d      = ST_BLANK;
            blank_d      = 1'b1;
            game_reset_d = 1'b1;
          end
        end
      end

      ST_BLANK: begin
        // Mode only changes on a frame boundary once the game has flushed.
        if (sw.vblank_start && !sw.game_busy) begin
          mode_d  = cand_q;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        cnt_clr   = 1'b0;
        cnt_en    = sw.vblank_start;
        cnt_limit = HOLD_LIM;
        if (cnt_hit) begin
          blank_d      = 1'b0;
          state_d      = ST_STABLE;
          game_start_d = (mode_q != MODE_IDLE);
        end
      end

      default: state_d = ST_STABLE;
    endcase
  end

  always_ff @(posedge clk65MHz or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_STABLE;
      mode_q       <= MODE_IDLE;
      cand_q       <= MODE_IDLE;
      blank_q      <= 1'b0;
      game_reset_q <= 1'b0;
      game_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cand_q       <= cand_d;
      blank_q      <= blank_d;
      game_reset_q <= game_reset_d;
      game_start_q <= game_start_d;
    end
  end

  assign sw.mode_out   = mode_q;
  assign sw.blank_out  = blank_q;
  assign sw.game_reset = game_reset_q;
  assign sw.game_start = game_start_q;

endmodule

// File: tb/tb_screen_switch_ctrl.sv
`timescale 1ns/1ps
module tb_screen_switch_ctrl;

  typedef struct {
    int vb;
    int mode;
    int blank;
    int rst_p;
    int start_p;
  } ev_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vb_cnt  = 0;
  bit   mon_en  = 1'b0;
  ev_t  exp_q[$];

  screen_switch_ctrl_if ifc();

  screen_switch_ctrl #(.STABLE_FRAMES(4), .HOLD_FRAMES(2)) dut (
    .clk65MHz (clk),
    .rst      (rst),
    .sw       (ifc)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int vb, input int mode, input int b,
                           input int r, input int s);
    ev_t e;
    e.vb = vb; e.mode = mode; e.blank = b; e.rst_p = r; e.start_p = s;
    exp_q.push_back(e);
  endtask

  // Each frame: a few active-video cycles, then a one-cycle vblank pulse.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(posedge clk);
      #1 ifc.vblank_start = 1'b1;
      vb_cnt++;
      @(posedge clk);
      #1 ifc.vblank_start = 1'b0;
    end
  endtask

  task automatic set_req(input logic i, input logic s, input logic m);
    ifc.screen_idle   = i;
    ifc.screen_single = s;
    ifc.screen_multi  = m;
  endtask

  // Monitor: any mode/blank change or pulse is an output event.
  initial begin
    int  prev_mode;
    int  prev_blank;
    int  cm, cb, cr, cs;
    ev_t e;
    prev_mode  = 0;
    prev_blank = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cm = int'(ifc.mode_out);
        cb = int'(ifc.blank_out);
        cr = int'(ifc.game_reset);
        cs = int'(ifc.game_start);
        if (cm != prev_mode || cb != prev_blank || cr != 0 || cs != 0) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event vb=%0d: got mode=%0d blank=%0d reset=%0d start=%0d, required no event",
                     vb_cnt, cm, cb, cr, cs);
          end else begin
            e = exp_q.pop_front();
            if (e.vb != vb_cnt || e.mode != cm || e.blank != cb ||
                e.rst_p != cr || e.start_p != cs) begin
              n_fail++;
              $display("FAIL event: got vb=%0d mode=%0d blank=%0d reset=%0d start=%0d, required vb=%0d mode=%0d blank=%0d reset=%0d start=%0d",
                       vb_cnt, cm, cb, cr, cs, e.vb, e.mode, e.blank, e.rst_p, e.start_p);
            end
          end
        end
        prev_mode  = cm;
        prev_blank = cb;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0;
    set_req(1'b1, 1'b0, 1'b0);
    ifc.vblank_start = 1'b0;
    ifc.game_busy    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mode",  int'(ifc.mode_out),   0);
    check("reset_blank", int'(ifc.blank_out),  0);
    check("reset_greset", int'(ifc.game_reset), 0);
    check("reset_gstart", int'(ifc.game_start), 0);
    rst    = 1'b1;
    mon_en = 1'b1;

    // Idle request held: nothing happens.
    frames(10);

    // Glitch: MULTI for 2 frames, then back to IDLE.
    set_req(1'b0, 1'b0, 1'b1);
    frames(2);
    set_req(1'b1, 1'b0, 1'b0);
    frames(6);

    // Clean IDLE -> SINGLE.
    base = vb_cnt;
    expect_ev(base + 4, 0, 1, 1, 0);
    expect_ev(base + 5, 1, 1, 0, 0);
    expect_ev(base + 7, 1, 0, 0, 1);
    set_req(1'b0, 1'b1, 1'b0);
    frames(7);

    // SINGLE -> MULTI with game_busy held for 3 frames in blank.
    base = vb_cnt;
    expect_ev(base + 4, 1, 1, 1, 0);
    expect_ev(base + 8, 2, 1, 0, 0);
    expect_ev(base + 10, 2, 0, 0, 1);
    set_req(1'b0, 1'b0, 1'b1);
    frames(4);
    ifc.game_busy = 1'b1;
    frames(3);
    check("busy_mode_held", int'(ifc.mode_out), 1);
    ifc.game_busy = 1'b0;
    frames(3);

    // MULTI -> SINGLE, request flips to MULTI during hold.
    base = vb_cnt;
    expect_ev(base + 4, 2, 1, 1, 0);
    expect_ev(base + 5, 1, 1, 0, 0);
    expect_ev(base + 7, 1, 0, 0, 1);
    expect_ev(base + 11, 1, 1, 1, 0);
    expect_ev(base + 12, 2, 1, 0, 0);
    expect_ev(base + 14, 2, 0, 0, 1);
    set_req(1'b0, 1'b1, 1'b0);
    frames(5);
    set_req(1'b0, 1'b0, 1'b1);
    frames(9);

    // Back to SINGLE, then illegal single+multi decodes as IDLE.
    base = vb_cnt;
    expect_ev(base + 4, 2, 1, 1, 0);
    expect_ev(base + 5, 1, 1, 0, 0);
    expect_ev(base + 7, 1, 0, 0, 1);
    set_req(1'b0, 1'b1, 1'b0);
    frames(7);
    base = vb_cnt;
    expect_ev(base + 4, 1, 1, 1, 0);
    expect_ev(base + 5, 0, 1, 0, 0);
    expect_ev(base + 7, 0, 0, 0, 0);
    set_req(1'b0, 1'b1, 1'b1);
    frames(7);

    // IDLE -> SINGLE, reset asserted asynchronously during hold.
    base = vb_cnt;
    expect_ev(base + 4, 0, 1, 1, 0);
    expect_ev(base + 5, 1, 1, 0, 0);
    expect_ev(base + 5, 0, 0, 0, 0);
    set_req(1'b0, 1'b1, 1'b0);
    frames(5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_mode",  int'(ifc.mode_out),  0);
    check("async_rst_blank", int'(ifc.blank_out), 0);
    set_req(1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    frames(3);

    repeat (5) @(posedge clk);
    check("all_events_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
